bcd_convert_seq: RTL

Sequential binary-to-BCD converter that sits directly upstream of the 8-digit seven-segment display stage. It accepts a binary value on a start strobe, runs the shift-and-add-3 (double-dabble) algorithm one bit per clock, and presents a registered, glitch-free 8-digit packed BCD word on the display stage's 32-bit data input. The output word changes only on completion, so the scanning display never sees a partial result.

---
 rtl/show_pkg.sv | 15 +
 rtl/bcd_add3_digit.sv | 10 +
 rtl/bcd_convert_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/show_pkg.sv
// Shared constants for the binary-to-BCD front end of the seven-segment display.
// Provides: BCD_DIGITS, BCD_WIDTH, BCD_SAT_VALUE and the converter FSM state encoding.
package show_pkg;

  localparam int unsigned BCD_DIGITS = 8;
  localparam int unsigned BCD_WIDTH  = 32;

  localparam logic [BCD_WIDTH-1:0] BCD_SAT_VALUE = 32'h9999_9999;

  // Converter FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
// Ports: digit (4-bit BCD digit in), corrected_c (4-bit corrected digit, combinational).
module bcd_add3_digit (
  input  logic [3:0] digit,
  output logic [3:0] corrected_c
);

  assign corrected_c = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding the
// 8-digit seven-segment display. bcd/overflow change only on completion.
// Build option: define BCD_OVERFLOW_SAT_EN to force bcd to 9999_9999 on overflow;
// otherwise bcd holds the value modulo 10^8.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start, binary     conversion request and the value sampled with it
//   busy              conversion in progress
//   done              one-cycle pulse when bcd/overflow are updated
//   overflow          last converted value exceeded 99_999_999
//   bcd               packed 8-digit BCD, digit 0 in [3:0]
module bcd_convert_seq
  import show_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] binary,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [BCD_WIDTH-1:0] bcd
);

  localparam int unsigned CNT_W = $clog2(BIN_WIDTH) + 1;

  logic [1:0]           state_q, state_d;
  logic [BIN_WIDTH-1:0] shreg_q, shreg_d;
  logic [BCD_WIDTH-1:0] scratch_q, scratch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 carry_q, carry_d;
  logic                 busy_d, done_d, overflow_d;
  logic [BCD_WIDTH-1:0] bcd_d;
  logic [BCD_WIDTH-1:0] corrected;

  // Parallel +3 correction of all scratch digits
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit      (scratch_q[4*g +: 4]),
      .corrected_c(corrected[4*g +: 4])
    );
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    busy_d     = busy;
    done_d     = 1'b0;
    overflow_d = overflow;
    bcd_d      = bcd;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SHIFT;
          shreg_d   = binary;
          scratch_d = '0;
          carry_d   = 1'b0;
          cnt_d     = CNT_W'(BIN_WIDTH - 1);
          busy_d    = 1'b1;
        end
      end

      ST_SHIFT: begin
        // Shift {corrected scratch, shreg} left; the bit leaving the top digit is a 10^8 carry
        scratch_d = {corrected[BCD_WIDTH-2:0], shreg_q[BIN_WIDTH-1]};
        shreg_d   = shreg_q << 1;
        carry_d   = carry_q | corrected[BCD_WIDTH-1];
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        overflow_d = carry_q;
`ifdef BCD_OVERFLOW_SAT_EN
        bcd_d      = carry_q ? BCD_SAT_VALUE : scratch_q;
`else
        bcd_d      = scratch_q;
`endif
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      bcd       <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      busy      <= busy_d;
      done      <= done_d;
      overflow  <= overflow_d;
      bcd       <= bcd_d;
    end
  end

endmodule
